edge_map_writer: RTL and testbench
==================================

Name: edge_map_writer

Overview:
- Sink-side partner of the Sobel Datapath: consumes the per-pixel edge stream (Dop, qualified by isReady, tagged with Out_Row/Out_Column, terminated by isEnd).
- Packs edge bits 8 per byte, MSB-first, with each row padded to whole bytes.
- Writes the bytes through a 4-entry FIFO to a byte-wide result memory port with ready backpressure.
- Asserts Done once the frame is fully written.

Parameters:
- OUT_W, 254, edge pixels per output row (1..256)
- OUT_H, 254, output rows per frame (1..256)
- ADDR_W, 13, result memory address width; must hold OUT_H*ceil(OUT_W/8)-1
- FIFO_D, 4, byte FIFO depth (power of two)

Ports:
- Clk  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-low reset
- Enable  in  1  frame armed; sampling only while high
- isReady  in  1  Dop/Out_Row/Out_Column valid this cycle
- Dop  in  1  edge bit (1 = edge)
- Out_Row  in  8  row index of the current pixel
- Out_Column  in  8  column index of the current pixel
- isEnd  in  1  last pixel of frame (coincident with its isReady)
- Wr_En  out  1  write request
- Wr_Addr  out  ADDR_W  byte address
- Wr_Data  out  8  packed edge byte
- Wr_Ready  in  1  memory accepts when Wr_En&&Wr_Ready
- Busy  out  1  frame in progress
- Done  out  1  frame fully written (level, held until Reset or Enable low)
- Overflow  out  1  sticky: byte lost because FIFO was full
- PosErr  out  1  sticky: pixel tag mismatched internal counters

Behaviour:
- Reset low, async: state IDLE; all outputs 0; counters, shift register and FIFO cleared. Reset mid-frame abandons the frame with no further writes.
- States:
  - IDLE -> COLLECT when Enable=1.
  - COLLECT -> DRAIN on an accepted pixel with isEnd=1.
  - DRAIN -> DONE when the FIFO is empty and the last write has been accepted.
  - DONE -> IDLE when Enable=0.
  - Enable=0 in COLLECT or DRAIN -> IDLE, FIFO flushed without writing.
- Busy=1 in COLLECT and DRAIN.
- Pixel accept: isReady=1 in COLLECT.
  - The bit shifts into the packer; the first pixel of each byte lands in bit 7.
  - Internal col/row counters advance; col wraps at OUT_W-1 and row increments.
  - isReady in other states is ignored.
- Position check on every accepted pixel: if Out_Row != row or Out_Column != col, set PosErr. Processing continues with the internal counters.
- Byte completion: a byte is pushed when 8 bits are collected, or when col == OUT_W-1 (row end), with unfilled low bits padded with 0.
  - BPR = ceil(OUT_W/8); OUT_W=254 gives 32 bytes/row, the last byte carrying 6 data bits and 2 zero pad bits.
- Address = row*BPR + byte_index, computed at push, stored alongside the data in the FIFO. Addresses are strictly sequential 0..OUT_H*BPR-1.
- isEnd pushes any partial byte, as for a row end. If isEnd arrives before row OUT_H-1, col OUT_W-1, set PosErr.
- FIFO entries are 8+ADDR_W bits, one push and one pop per cycle.
  - Wr_En=1 whenever the FIFO is non-empty; Wr_Data/Wr_Addr come from the head entry and are registered outputs.
  - Pop on Wr_En&&Wr_Ready.
  - Wr_Data/Wr_Addr stay stable while Wr_En=1 and Wr_Ready=0.
  - Simultaneous push and pop on a full FIFO is legal; no overflow is flagged.
- Overflow: a push attempted while the FIFO is full and no pop occurs that cycle. The byte is dropped, Overflow set sticky, and the address counter still advances.
- Latency: a pushed byte is presented on Wr_En/Wr_Data/Wr_Addr the cycle after the push edge when the FIFO was empty.
- Done rises the cycle after the final write is accepted.

Test Plan:
- Nominal small frame (OUT_W=8, OUT_H=2, Wr_Ready=1). Stream Dop=1,0,1,0,1,0,1,0 then 8×1, with correct tags and isEnd on the last pixel. Required: writes (0,8'hAA) then (1,8'hFF), then Done=1 with PosErr=0 and Overflow=0.
- Padding (OUT_W=254, OUT_H=1, all Dop=1). Required: 32 writes at addresses 0..31, bytes 0..30 = 8'hFF, byte 31 = 8'hFC, then Done.
- Backpressure (OUT_W=32, Wr_Ready=0 for 40 cycles then 1). Required: Wr_En held, Wr_Data/Wr_Addr stable, 4 bytes delivered in order, Overflow=0.
- Overflow (OUT_W=48, Wr_Ready=0 throughout). Required: 5th byte push sets Overflow=1; releasing Wr_Ready delivers addresses 0..3 only.
- Tag error: feed Out_Column=5 where col=4. Required: PosErr=1 sticky; packing and addresses unaffected.
- Reset mid-frame: Reset low after 100 pixels. Required: all outputs 0 asynchronously, no Wr_En afterwards; a new frame restarts at address 0.

Source files
------------

// File: rtl/edge_map_writer_if.sv
// Byte-wide result-memory write port: the writer drives address/data/enable, the memory returns ready.
// A beat transfers on the cycle where Wr_En and Wr_Ready are both high.
interface edge_map_writer_if #(
    parameter int ADDR_W = 13
) ();
    logic              Wr_En;
    logic [ADDR_W-1:0] Wr_Addr;
    logic [7:0]        Wr_Data;
    logic              Wr_Ready;

    modport master (output Wr_En, output Wr_Addr, output Wr_Data, input Wr_Ready);
    modport slave  (input Wr_En, input Wr_Addr, input Wr_Data, output Wr_Ready);
endinterface

// File: rtl/edge_map_writer.sv
// Packs the Sobel edge-bit stream MSB-first into row-padded bytes and writes them through a small FIFO.
// A pushed byte reaches the write port one cycle later; Wr_Ready low stalls the head and full-FIFO pushes are dropped.
module edge_map_writer #(
    parameter int OUT_W  = 254,
    parameter int OUT_H  = 254,
    parameter int ADDR_W = 13,
    parameter int FIFO_D = 4
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Enable,
    input  logic       isReady,
    input  logic       Dop,
    input  logic [7:0] Out_Row,
    input  logic [7:0] Out_Column,
    input  logic       isEnd,
    edge_map_writer_if.master wr,
    output logic       Busy,
    output logic       Done,
    output logic       Overflow,
    output logic       PosErr
);
    localparam int PW = $clog2(FIFO_D);
    localparam logic [7:0] COL_LAST = 8'(OUT_W - 1);
    localparam logic [7:0] ROW_LAST = 8'(OUT_H - 1);

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DRAIN, S_DONE} state_t;

    typedef struct packed {
        logic [7:0]        dat;
        logic [ADDR_W-1:0] addr;
    } ent_t;

    state_t            state_q, state_d;
    logic [7:0]        col_q, row_q;
    logic [2:0]        bit_q;
    logic [7:0]        sr_q;
    logic [ADDR_W-1:0] addr_q;
    logic              ovf_q, poserr_q;

    ent_t              mem_q [FIFO_D];
    logic [PW-1:0]     rd_q, wr_q;
    logic [PW:0]       cnt_q;
    logic              wr_en_q;
    logic [7:0]        wr_dat_q;
    logic [ADDR_W-1:0] wr_addr_q;

    logic              accept, row_end, push, push_ok, pop, full, ovf, pos_bad, flush;
    logic [7:0]        bit_set, byte_dat;
    logic [PW:0]       cnt_nxt;
    logic [PW-1:0]     rd_nxt, wr_nxt;
    ent_t              new_ent, head_nxt;

    // Packer and position check
    always_comb begin
        accept   = (state_q == S_COLLECT) && Enable && isReady;
        row_end  = (col_q == COL_LAST);
        bit_set  = 8'(Dop) << (3'd7 - bit_q);
        byte_dat = sr_q | bit_set;
        push     = accept && ((bit_q == 3'd7) || row_end || isEnd);
        pos_bad  = accept && ((Out_Row != row_q) || (Out_Column != col_q) ||
                              (isEnd && !(row_end && (row_q == ROW_LAST))));
        new_ent  = '{dat: byte_dat, addr: addr_q};
    end

    // FIFO bookkeeping; the head is pre-computed so the write port is driven straight from flops
    always_comb begin
        pop      = wr_en_q && wr.Wr_Ready;
        full     = (cnt_q == (PW+1)'(FIFO_D));
        push_ok  = push && (!full || pop);
        ovf      = push && full && !pop;
        cnt_nxt  = cnt_q + {{PW{1'b0}}, push_ok} - {{PW{1'b0}}, pop};
        rd_nxt   = rd_q + PW'(pop);
        wr_nxt   = wr_q + PW'(push_ok);
        head_nxt = (push_ok && (wr_q == rd_nxt)) ? new_ent : mem_q[rd_nxt];
    end

    always_comb begin
        state_d = state_q;
        flush   = 1'b0;
        case (state_q)
            S_IDLE:    if (Enable) state_d = S_COLLECT;
            S_COLLECT: begin
                if (!Enable) begin
                    state_d = S_IDLE;
                    flush   = 1'b1;
                end else if (accept && isEnd) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!Enable) begin
                    state_d = S_IDLE;
                    flush   = 1'b1;
                end else if (cnt_nxt == '0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:    if (!Enable) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            col_q    <= '0;
            row_q    <= '0;
            bit_q    <= '0;
            sr_q     <= '0;
            addr_q   <= '0;
            ovf_q    <= 1'b0;
            poserr_q <= 1'b0;
        end else begin
            ovf_q    <= ovf_q | ovf;
            poserr_q <= poserr_q | pos_bad;
            if (state_q == S_IDLE) begin
                col_q  <= '0;
                row_q  <= '0;
                bit_q  <= '0;
                sr_q   <= '0;
                addr_q <= '0;
            end else if (accept) begin
                // Dropped bytes still consume an address so later bytes land where they belong
                if (push) begin
                    sr_q   <= '0;
                    bit_q  <= '0;
                    addr_q <= addr_q + ADDR_W'(1);
                end else begin
                    sr_q   <= byte_dat;
                    bit_q  <= bit_q + 3'd1;
                end
                if (row_end) begin
                    col_q <= '0;
                    row_q <= row_q + 8'd1;
                end else begin
                    col_q <= col_q + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < FIFO_D; i++) mem_q[i] <= '0;
        end else if (push_ok && !flush) begin
            mem_q[wr_q] <= new_ent;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            rd_q      <= '0;
            wr_q      <= '0;
            cnt_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_dat_q  <= '0;
            wr_addr_q <= '0;
        end else if (flush) begin
            rd_q      <= '0;
            wr_q      <= '0;
            cnt_q     <= '0;
            wr_en_q   <= 1'b0;
        end else begin
            rd_q    <= rd_nxt;
            wr_q    <= wr_nxt;
            cnt_q   <= cnt_nxt;
            wr_en_q <= (cnt_nxt != '0);
            if (cnt_nxt != '0) begin
                wr_dat_q  <= head_nxt.dat;
                wr_addr_q <= head_nxt.addr;
            end
        end
    end

    assign wr.Wr_En   = wr_en_q;
    assign wr.Wr_Data = wr_dat_q;
    assign wr.Wr_Addr = wr_addr_q;
    assign Busy       = (state_q == S_COLLECT) || (state_q == S_DRAIN);
    assign Done       = (state_q == S_DONE);
    assign Overflow   = ovf_q;
    assign PosErr     = poserr_q;
endmodule

// File: tb/tb_edge_map_writer.sv
// Directed bench for edge_map_writer on a 12x3 frame (two bytes per row, second byte half padding).
// Expected writes are queued as pixels are driven and matched against the write port.
module tb_edge_map_writer;
    localparam int W = 12;
    localparam int H = 3;
    localparam int AW = 4;
    localparam int NPIX = W * H;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [7:0]    dat;
    } exp_t;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       Enable = 1'b0;
    logic       isReady = 1'b0;
    logic       Dop = 1'b0;
    logic [7:0] Out_Row = '0;
    logic [7:0] Out_Column = '0;
    logic       isEnd = 1'b0;
    logic       Busy, Done, Overflow, PosErr;

    edge_map_writer_if #(.ADDR_W(AW)) wif ();

    edge_map_writer #(.OUT_W(W), .OUT_H(H), .ADDR_W(AW), .FIFO_D(4)) dut (
        .Clk(Clk), .Reset(Reset), .Enable(Enable), .isReady(isReady), .Dop(Dop),
        .Out_Row(Out_Row), .Out_Column(Out_Column), .isEnd(isEnd), .wr(wif),
        .Busy(Busy), .Done(Done), .Overflow(Overflow), .PosErr(PosErr)
    );

    always #5 Clk = ~Clk;

    int         n_assert = 0;
    int         n_fail = 0;
    int         n_writes = 0;
    int         max_exp = 1000;
    int         bad_idx = -1;
    logic [11:0] rows [H];
    exp_t       sb [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Write-port monitor: every accepted beat must match the oldest queued expectation
    always @(negedge Clk) begin
        if (Reset && wif.Wr_En && wif.Wr_Ready) begin
            exp_t e;
            n_writes++;
            if (sb.size() == 0) begin
                chk("unexpected_write_addr", {28'd0, wif.Wr_Addr}, 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                chk("wr_addr", {28'd0, wif.Wr_Addr}, {28'd0, e.addr});
                chk("wr_data", {24'd0, wif.Wr_Data}, {24'd0, e.dat});
            end
        end
    end

    task automatic send_range(input int first, input int last);
        for (int idx = first; idx <= last; idx++) begin
            int r, c;
            exp_t e;
            logic [11:0] rv;
            r  = idx / W;
            c  = idx % W;
            rv = rows[r];
            isReady    = 1'b1;
            Dop        = rv[11 - c];
            Out_Row    = 8'(r);
            Out_Column = (idx == bad_idx) ? 8'(c + 1) : 8'(c);
            isEnd      = (idx == NPIX - 1);
            if (c == 7 || c == 11) begin
                e.addr = AW'(2 * r + (c == 11 ? 1 : 0));
                e.dat  = (c == 7) ? rv[11:4] : {rv[3:0], 4'h0};
                if (int'(e.addr) < max_exp) sb.push_back(e);
            end
            @(posedge Clk); #1;
        end
        isReady = 1'b0;
        isEnd   = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 200 && !Done; i++) @(negedge Clk);
        chk(tag, {31'd0, Done}, 32'd1);
        chk({tag, "_sb_empty"}, sb.size(), 0);
    endtask

    task automatic restart();
        Enable = 1'b0;
        Reset  = 1'b0;
        sb.delete();
        @(posedge Clk); #1;
        Reset  = 1'b1;
        max_exp = 1000;
        bad_idx = -1;
        @(posedge Clk); #1;
    endtask

    initial begin
        int wcount;
        wif.Wr_Ready = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        chk("rst_wr_en", {31'd0, wif.Wr_En}, 0);
        chk("rst_wr_addr", {28'd0, wif.Wr_Addr}, 0);
        chk("rst_wr_data", {24'd0, wif.Wr_Data}, 0);
        chk("rst_flags", {28'd0, Busy, Done, Overflow, PosErr}, 0);

        // Nominal frame, including first-byte latency
        Reset = 1'b1;
        rows[0] = 12'b1010_1010_1100;
        rows[1] = 12'hFFF;
        rows[2] = 12'b0000_0000_0001;
        Enable = 1'b1;
        @(posedge Clk); #1;
        chk("busy_collect", {31'd0, Busy}, 1);
        send_range(0, 7);
        @(negedge Clk);
        chk("lat_wr_en", {31'd0, wif.Wr_En}, 1);
        @(posedge Clk); #1;
        send_range(8, NPIX - 1);
        wait_done("nominal_done");
        chk("nominal_flags", {30'd0, Overflow, PosErr}, 0);
        chk("nominal_busy", {31'd0, Busy}, 0);
        @(posedge Clk); #1;
        Enable = 1'b0;
        @(posedge Clk); #1;
        chk("done_clear", {31'd0, Done}, 0);

        // Backpressure: four bytes stall in the FIFO for 40 cycles
        restart();
        rows[0] = 12'h5A3;
        rows[1] = 12'h0F9;
        rows[2] = 12'hC6E;
        wif.Wr_Ready = 1'b0;
        Enable = 1'b1;
        @(posedge Clk); #1;
        send_range(0, 2 * W - 1);
        for (int i = 0; i < 40; i++) begin
            @(negedge Clk);
            if (i % 10 == 0) begin
                chk("bp_wr_en", {31'd0, wif.Wr_En}, 1);
                chk("bp_addr", {28'd0, wif.Wr_Addr}, 0);
                chk("bp_data", {24'd0, wif.Wr_Data}, 32'h5A);
            end
        end
        @(posedge Clk); #1;
        wif.Wr_Ready = 1'b1;
        send_range(2 * W, NPIX - 1);
        wait_done("bp_done");
        chk("bp_overflow", {31'd0, Overflow}, 0);

        // Overflow: memory never ready while the frame streams in
        restart();
        rows[0] = 12'h123;
        rows[1] = 12'h456;
        rows[2] = 12'h789;
        max_exp = 4;
        wif.Wr_Ready = 1'b0;
        Enable = 1'b1;
        @(posedge Clk); #1;
        wcount = n_writes;
        send_range(0, 2 * W - 1);
        chk("ovf_before", {31'd0, Overflow}, 0);
        send_range(2 * W, NPIX - 1);
        chk("ovf_after", {31'd0, Overflow}, 1);
        wif.Wr_Ready = 1'b1;
        wait_done("ovf_done");
        chk("ovf_write_count", n_writes - wcount, 4);

        // Tag error on row 0, column 4
        restart();
        rows[0] = 12'hE71;
        rows[1] = 12'h3C5;
        rows[2] = 12'hA0F;
        bad_idx = 4;
        Enable = 1'b1;
        @(posedge Clk); #1;
        send_range(0, 3);
        chk("poserr_clean", {31'd0, PosErr}, 0);
        send_range(4, NPIX - 1);
        wait_done("tag_done");
        chk("poserr_set", {31'd0, PosErr}, 1);
        Enable = 1'b0;
        @(posedge Clk); #1;
        chk("poserr_sticky", {31'd0, PosErr}, 1);

        // Asynchronous reset mid-frame with bytes pending
        restart();
        rows[0] = 12'hBEE;
        rows[1] = 12'h1D2;
        rows[2] = 12'h6B4;
        wif.Wr_Ready = 1'b0;
        Enable = 1'b1;
        @(posedge Clk); #1;
        send_range(0, 19);
        chk("mid_wr_en", {31'd0, wif.Wr_En}, 1);
        #2;
        Reset = 1'b0;
        #1;
        chk("async_wr_en", {31'd0, wif.Wr_En}, 0);
        chk("async_busy", {31'd0, Busy}, 0);
        chk("async_data", {24'd0, wif.Wr_Data}, 0);
        sb.delete();
        Enable = 1'b0;
        wif.Wr_Ready = 1'b1;
        @(posedge Clk); #1;
        Reset = 1'b1;
        wcount = n_writes;
        repeat (10) @(posedge Clk);
        #1;
        chk("post_rst_no_write", n_writes - wcount, 0);
        chk("post_rst_wr_en", {31'd0, wif.Wr_En}, 0);
        rows[0] = 12'h0F0;
        rows[1] = 12'hF0F;
        rows[2] = 12'h999;
        Enable = 1'b1;
        @(posedge Clk); #1;
        send_range(0, NPIX - 1);
        wait_done("restart_done");
        chk("restart_flags", {30'd0, Overflow, PosErr}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
